// File: rtl/usart_echo_tester.sv
// usart_echo_tester: 8N1 link-test initiator. Sends seed, seed+1, ... on tx_pin one byte at a time
// and scores each echo returned on rx_pin as pass, mismatch, framing error or timeout.
module usart_echo_tester #(
    parameter int TIMEOUT_BITS = 40,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   serial_clock,
    input  logic                   reset,
    input  logic [11:0]            clocks_per_bit,
    input  logic                   start,
    input  logic [7:0]             seed,
    input  logic [COUNT_WIDTH-1:0] byte_count,
    input  logic                   cts_pin,
    input  logic                   rx_pin,
    output logic                   tx_pin,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] pass_count,
    output logic [COUNT_WIDTH-1:0] error_count,
    output logic [COUNT_WIDTH-1:0] timeout_count,
    output logic [7:0]             last_bad_data
);
    localparam int TW = 12 + $clog2(TIMEOUT_BITS + 1);

    typedef enum logic [2:0] {IDLE, WAIT_CTS, TX, WAIT_ECHO, RX, CHECK, FINISH} state_t;

    state_t                 state_q;
    logic [11:0]            cpb_q, bitTimer_q;
    logic [3:0]             bitIdx_q;
    logic [7:0]             txByte_q, rxShift_q, lastBad_q;
    logic                   rxStop_q;
    logic [COUNT_WIDTH-1:0] total_q, index_q, pass_q, error_q, timeout_q;
    logic [TW-1:0]          toTimer_q;
    logic                   tx_q, busy_q, done_q;
    logic                   rxMeta_q, rxSync_q, rxPrev_q;

    logic                   rxFall_d;
    logic [COUNT_WIDTH-1:0] indexNext_d;
    logic [TW-1:0]          toLoad_d;
    logic [9:0]             txFrame_d;

    assign rxFall_d    = rxPrev_q & ~rxSync_q;
    assign indexNext_d = index_q + 1'b1;
    // Loaded one short so the byte is declared lost exactly TIMEOUT_BITS bit periods after the stop bit.
    assign toLoad_d    = TW'(TIMEOUT_BITS) * TW'(cpb_q) - TW'(1);
    assign txFrame_d   = {1'b1, txByte_q, 1'b0};

    function automatic logic [COUNT_WIDTH-1:0] satInc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge serial_clock) begin
        if (!reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= rx_pin;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    always_ff @(posedge serial_clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            cpb_q      <= '0;
            bitTimer_q <= '0;
            bitIdx_q   <= '0;
            txByte_q   <= '0;
            rxShift_q  <= '0;
            rxStop_q   <= 1'b0;
            total_q    <= '0;
            index_q    <= '0;
            pass_q     <= '0;
            error_q    <= '0;
            timeout_q  <= '0;
            toTimer_q  <= '0;
            lastBad_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        cpb_q     <= clocks_per_bit;
                        txByte_q  <= seed;
                        total_q   <= byte_count;
                        index_q   <= '0;
                        pass_q    <= '0;
                        error_q   <= '0;
                        timeout_q <= '0;
                        if (byte_count != '0) begin
                            state_q <= WAIT_CTS;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= FINISH;
                        end
                    end
                end
                WAIT_CTS: begin
                    if (!cts_pin) begin
                        state_q    <= TX;
                        tx_q       <= 1'b0;
                        bitTimer_q <= cpb_q - 12'd1;
                        bitIdx_q   <= '0;
                    end
                end
                TX: begin
                    if (bitTimer_q != 12'd0) begin
                        bitTimer_q <= bitTimer_q - 12'd1;
                    end else if (bitIdx_q == 4'd9) begin
                        state_q   <= WAIT_ECHO;
                        toTimer_q <= toLoad_d;
                    end else begin
                        bitTimer_q <= cpb_q - 12'd1;
                        bitIdx_q   <= bitIdx_q + 4'd1;
                        tx_q       <= txFrame_d[bitIdx_q + 4'd1];
                    end
                end
                WAIT_ECHO: begin
                    // An edge wins over a simultaneous expiry.
                    if (rxFall_d) begin
                        state_q    <= RX;
                        bitIdx_q   <= '0;
                        bitTimer_q <= (cpb_q >> 1) - 12'd1;
                    end else if (toTimer_q == '0) begin
                        timeout_q <= satInc(timeout_q);
                        index_q   <= indexNext_d;
                        txByte_q  <= txByte_q + 8'd1;
                        state_q   <= (indexNext_d == total_q) ? FINISH : WAIT_CTS;
                    end else begin
                        toTimer_q <= toTimer_q - TW'(1);
                    end
                end
                RX: begin
                    if (bitTimer_q != 12'd0) begin
                        bitTimer_q <= bitTimer_q - 12'd1;
                    end else begin
                        bitTimer_q <= cpb_q - 12'd1;
                        bitIdx_q   <= bitIdx_q + 4'd1;
                        if (bitIdx_q == 4'd0) begin
                            if (rxSync_q) begin
                                state_q <= WAIT_ECHO;
                            end
                        end else if (bitIdx_q == 4'd9) begin
                            rxStop_q <= rxSync_q;
                            state_q  <= CHECK;
                        end else begin
                            rxShift_q <= {rxSync_q, rxShift_q[7:1]};
                        end
                    end
                end
                CHECK: begin
                    if (!rxStop_q || rxShift_q != txByte_q) begin
                        error_q   <= satInc(error_q);
                        lastBad_q <= rxShift_q;
                    end else begin
                        pass_q <= satInc(pass_q);
                    end
                    index_q  <= indexNext_d;
                    txByte_q <= txByte_q + 8'd1;
                    state_q  <= (indexNext_d == total_q) ? FINISH : WAIT_CTS;
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_pin        = tx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass_count    = pass_q;
    assign error_count   = error_q;
    assign timeout_count = timeout_q;
    assign last_bad_data = lastBad_q;

endmodule

// File: tb/tb_usart_echo_tester.sv
// tb_usart_echo_tester: directed and randomized runs against an echoing far end modelled in the bench,
// with expected tallies computed per byte from the echo behaviour chosen for each run.
module tb_usart_echo_tester;
    localparam int TIMEOUT_BITS = 40;
    localparam int COUNT_WIDTH  = 16;

    logic                   serial_clock = 1'b0;
    logic                   reset        = 1'b0;
    logic [11:0]            clocks_per_bit = 12'd16;
    logic                   start        = 1'b0;
    logic [7:0]             seed         = 8'h00;
    logic [COUNT_WIDTH-1:0] byte_count   = '0;
    logic                   cts_pin      = 1'b0;
    logic                   rx_pin;
    logic                   tx_pin;
    logic                   busy;
    logic                   done;
    logic [COUNT_WIDTH-1:0] pass_count;
    logic [COUNT_WIDTH-1:0] error_count;
    logic [COUNT_WIDTH-1:0] timeout_count;
    logic [7:0]             last_bad_data;

    int         checks = 0;
    int         errors = 0;
    int         cpb = 16;
    logic [7:0] echoSeed = 8'h00;
    bit         echoMode = 1'b1;
    bit         glitch   = 1'b0;
    logic [7:0] corrupt [0:255];
    bit         badStop [0:255];
    logic [7:0] txLog [0:255];
    int         txCount = 0;
    logic       rxBench = 1'b1;
    logic [7:0] modelLast = 8'h00;

    assign rx_pin = rxBench;

    usart_echo_tester #(.TIMEOUT_BITS(TIMEOUT_BITS), .COUNT_WIDTH(COUNT_WIDTH)) dut (
        .serial_clock  (serial_clock),
        .reset         (reset),
        .clocks_per_bit(clocks_per_bit),
        .start         (start),
        .seed          (seed),
        .byte_count    (byte_count),
        .cts_pin       (cts_pin),
        .rx_pin        (rx_pin),
        .tx_pin        (tx_pin),
        .busy          (busy),
        .done          (done),
        .pass_count    (pass_count),
        .error_count   (error_count),
        .timeout_count (timeout_count),
        .last_bad_data (last_bad_data)
    );

    always #5 serial_clock = ~serial_clock;

    // Decodes every frame on tx_pin by mid-bit sampling and logs the byte.
    initial begin : txMonitor
        logic [7:0] b;
        forever begin
            @(negedge tx_pin);
            repeat (cpb / 2) @(negedge serial_clock);
            for (int i = 0; i < 8; i++) begin
                repeat (cpb) @(negedge serial_clock);
                b[i] = tx_pin;
            end
            repeat (cpb) @(negedge serial_clock);
            txLog[8'(txCount)] = b;
            txCount++;
        end
    end

    // Far end: returns each logged byte after the tester's stop bit, optionally corrupted,
    // mis-framed or preceded by a short glitch.
    initial begin : echoSender
        int         ptr;
        logic [7:0] b;
        logic [7:0] idx;
        ptr = 0;
        forever begin
            wait (txCount > ptr);
            b = txLog[8'(ptr)];
            ptr++;
            if (echoMode) begin
                idx = b - echoSeed;
                b = b ^ corrupt[idx];
                repeat (cpb + 2) @(negedge serial_clock);
                if (glitch) begin
                    rxBench = 1'b0;
                    repeat (2) @(negedge serial_clock);
                    rxBench = 1'b1;
                    repeat (20) @(negedge serial_clock);
                end
                rxBench = 1'b0;
                repeat (cpb) @(negedge serial_clock);
                for (int i = 0; i < 8; i++) begin
                    rxBench = b[i];
                    repeat (cpb) @(negedge serial_clock);
                end
                rxBench = ~badStop[idx];
                repeat (cpb) @(negedge serial_clock);
                rxBench = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("[TB] FAIL watchdog: observed no summary by time %0t, expected run to complete", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearEcho();
        for (int i = 0; i < 256; i++) begin
            corrupt[i] = 8'h00;
            badStop[i] = 1'b0;
        end
        glitch = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] s, input int n, input int c);
        cpb            = c;
        echoSeed       = s;
        clocks_per_bit = 12'(c);
        seed           = s;
        byte_count     = 16'(n);
        @(negedge serial_clock);
        start = 1'b1;
        @(negedge serial_clock);
        start = 1'b0;
    endtask

    task automatic waitTxLow(input string tag, input int limit);
        int cyc = 0;
        while (tx_pin !== 1'b0 && cyc < limit) begin
            @(negedge serial_clock);
            cyc++;
        end
        checkOutput(tag, 32'(tx_pin), 32'd0);
    endtask

    // Waits for done, then compares frames and tallies with the per-byte reference model.
    task automatic finishRun(input string tag, input int base, input logic [7:0] s, input int n);
        int         cyc = 0;
        int         expPass = 0;
        int         expErr = 0;
        int         expTo = 0;
        logic [7:0] b;
        logic [7:0] e;
        while (done !== 1'b1 && cyc < n * 60 * cpb + 500) begin
            @(negedge serial_clock);
            cyc++;
        end
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        for (int k = 0; k < n; k++) begin
            b = s + 8'(k);
            checkOutput($sformatf("%s_tx%0d", tag, k), 32'(txLog[8'(base + k)]), 32'(b));
            if (!echoMode) begin
                expTo++;
            end else begin
                e = b ^ corrupt[k];
                if (badStop[k] || e != b) begin
                    expErr++;
                    modelLast = e;
                end else begin
                    expPass++;
                end
            end
        end
        checkOutput({tag, "_pass"}, 32'(pass_count), 32'(expPass));
        checkOutput({tag, "_err"}, 32'(error_count), 32'(expErr));
        checkOutput({tag, "_timeout"}, 32'(timeout_count), 32'(expTo));
        checkOutput({tag, "_lastbad"}, 32'(last_bad_data), 32'(modelLast));
        repeat (3 * cpb + 20) @(negedge serial_clock);
    endtask

    initial begin : main
        int         base;
        int         cyc;
        bit         anyLow;
        logic [7:0] s;
        int         n;
        int         c;
        int         t;

        clearEcho();
        repeat (5) @(negedge serial_clock);
        checkOutput("rst_tx", 32'(tx_pin), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass_count), 32'd0);
        checkOutput("rst_err", 32'(error_count), 32'd0);
        checkOutput("rst_timeout", 32'(timeout_count), 32'd0);
        checkOutput("rst_lastbad", 32'(last_bad_data), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge serial_clock);

        $display("[TB] basic echo run with an ignored start mid-run");
        base = txCount;
        applyStimulus(8'h30, 4, 16);
        checkOutput("basic_busy_after_start", 32'(busy), 32'd1);
        repeat (60) @(negedge serial_clock);
        seed = 8'h55;
        byte_count = 16'd9;
        start = 1'b1;
        @(negedge serial_clock);
        start = 1'b0;
        finishRun("basic", base, 8'h30, 4);

        $display("[TB] zero-length run");
        base = txCount;
        applyStimulus(8'h00, 0, 16);
        finishRun("zero", base, 8'h00, 0);

        $display("[TB] sequence wrap");
        base = txCount;
        applyStimulus(8'hFF, 2, 16);
        finishRun("wrap", base, 8'hFF, 2);

        $display("[TB] corrupted echo");
        clearEcho();
        corrupt[1] = 8'h01;
        base = txCount;
        applyStimulus(8'h10, 3, 16);
        finishRun("corrupt", base, 8'h10, 3);
        checkOutput("corrupt_lastbad_value", 32'(last_bad_data), 32'h10);

        $display("[TB] no echo");
        clearEcho();
        echoMode = 1'b0;
        base = txCount;
        applyStimulus(8'hA0, 2, 8);
        waitTxLow("timeout_tx_start", 200);
        cyc = 0;
        while (timeout_count == '0 && cyc < 2000) begin
            @(negedge serial_clock);
            cyc++;
        end
        checkOutput("timeout_latency", 32'(cyc), 32'(10 * 8 + TIMEOUT_BITS * 8));
        finishRun("timeout", base, 8'hA0, 2);
        echoMode = 1'b1;

        $display("[TB] framing error");
        clearEcho();
        badStop[0] = 1'b1;
        s = 8'($urandom);
        base = txCount;
        applyStimulus(s, 1, 16);
        finishRun("framing", base, s, 1);

        $display("[TB] glitch before echo");
        clearEcho();
        glitch = 1'b1;
        base = txCount;
        applyStimulus(8'h5A, 1, 16);
        finishRun("glitch", base, 8'h5A, 1);
        clearEcho();

        $display("[TB] flow control");
        cts_pin = 1'b1;
        base = txCount;
        applyStimulus(8'h77, 1, 16);
        anyLow = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge serial_clock);
            if (tx_pin !== 1'b1) anyLow = 1'b1;
        end
        checkOutput("cts_hold_tx_high", 32'(anyLow), 32'd0);
        checkOutput("cts_hold_busy", 32'(busy), 32'd1);
        cts_pin = 1'b0;
        @(negedge serial_clock);
        checkOutput("cts_release_tx_start", 32'(tx_pin), 32'd0);
        finishRun("cts", base, 8'h77, 1);

        $display("[TB] reset mid-transmit");
        applyStimulus(8'($urandom), 3, 16);
        cyc = 0;
        while (pass_count != 16'd1 && cyc < 3000) begin
            @(negedge serial_clock);
            cyc++;
        end
        checkOutput("midrst_first_pass", 32'(pass_count), 32'd1);
        waitTxLow("midrst_second_frame", 500);
        repeat (20) @(negedge serial_clock);
        reset = 1'b0;
        @(negedge serial_clock);
        checkOutput("midrst_tx", 32'(tx_pin), 32'd1);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_pass", 32'(pass_count), 32'd0);
        checkOutput("midrst_err", 32'(error_count), 32'd0);
        checkOutput("midrst_timeout", 32'(timeout_count), 32'd0);
        checkOutput("midrst_lastbad", 32'(last_bad_data), 32'd0);
        modelLast = 8'h00;
        repeat (3) @(negedge serial_clock);
        reset = 1'b1;
        repeat (800) @(negedge serial_clock);
        s = 8'($urandom);
        base = txCount;
        applyStimulus(s, 2, 16);
        finishRun("after_rst", base, s, 2);

        $display("[TB] randomized echo runs");
        for (int r = 0; r < 4; r++) begin
            clearEcho();
            s = 8'($urandom);
            n = int'($urandom_range(4, 1));
            c = int'($urandom_range(12, 4));
            for (int k = 0; k < n; k++) begin
                t = int'($urandom_range(2, 0));
                if (t == 1) corrupt[k] = 8'($urandom_range(255, 1));
                if (t == 2) badStop[k] = 1'b1;
            end
            base = txCount;
            applyStimulus(s, n, c);
            finishRun($sformatf("rand%0d", r), base, s, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
